// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key handling path (debouncer and event decoder).
//   - State encoding of the key event decoder FSM (3-bit, legacy-compatible).
//   - Default timing constants derived from the system clock frequency, so the
//     debouncer and the decoder agree on what one millisecond tick is.
//   - Event bundle type and a small threshold helper used by the decoder.
// -----------------------------------------------------------------------------
package key_pkg;

    // Decoder FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_WAIT2  = 3'd3;
    localparam logic [2:0] ST_PRESS2 = 3'd4;

    // System clock frequency, shared with the debouncer's CLK_freq
    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned TICK_HZ     = 1_000;

    // Default timing: 1 ms ticks
    localparam int unsigned DEF_TICK_CYC     = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned DEF_LONG_TICKS   = 1000;
    localparam int unsigned DEF_REPEAT_TICKS = 200;
    localparam int unsigned DEF_DCLICK_TICKS = 300;
    localparam int unsigned DEF_CNT_W        = 16;

    // One-cycle event strobes produced by the decoder
    typedef struct packed {
        logic short_ev;
        logic double_ev;
        logic long_ev;
        logic repeat_ev;
    } key_ev_t;

    // A threshold of n ticks is reached on the cycle where the counter already
    // holds n-1 completed ticks and the prescaler is producing the n-th one.
    function automatic logic threshold_met(input logic [31:0] cnt,
                                           input logic        tick,
                                           input int unsigned n);
        return tick && (cnt == (n - 32'd1));
    endfunction

endpackage

// File: rtl/key_tick_gen.sv
// -----------------------------------------------------------------------------
// key_tick_gen
// Timebase for the key event decoder: a prescaler that divides clk_i down to
// one tick every TICK_CYC cycles, followed by a tick counter.
//
// Ports
//   clk_i    in   system clock
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   synchronous clear of prescaler and tick counter (takes
//                 priority over counting on the same edge)
//   tick_o   out  high during the last prescaler cycle of each tick period
//   count_o  out  number of completed ticks since the last clear (saturating)
// -----------------------------------------------------------------------------
module key_tick_gen #(
    parameter int unsigned TICK_CYC = 100_000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clear_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    // A 1-bit prescaler is still needed when TICK_CYC is 1; it simply stays 0
    // and every cycle is a tick.
    localparam int unsigned    PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_CYC - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o  = (pre_q == PRE_LAST);
    assign count_o = cnt_q;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            if (tick_o) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
            // Saturate rather than wrap so a stale count can never alias a
            // small threshold value.
            if (tick_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Classifies a debounced key level into short press, double click, long press
// and auto-repeat events for the application control logic.
//
// Ports
//   clk_i      in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_down   in   debounced key level, 1 = pressed, synchronous to clk_i
//   ev_short   out  one-cycle strobe: single short press completed
//   ev_double  out  one-cycle strobe: second press inside the double-click window
//   ev_long    out  one-cycle strobe: hold reached LONG_TICKS
//   ev_repeat  out  one-cycle strobe: auto-repeat while held after ev_long
//   busy       out  high whenever the FSM is not in IDLE
//
// All strobes are registered: each is high for the cycle after the edge that
// takes its transition. A key_down change always wins over a timing threshold
// reached on the same cycle.
// -----------------------------------------------------------------------------
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned TICK_CYC     = DEF_TICK_CYC,
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic key_down,
    output logic ev_short,
    output logic ev_double,
    output logic ev_long,
    output logic ev_repeat,
    output logic busy
);

    logic [2:0]       state_q, state_d;
    key_ev_t          ev_q, ev_d;
    logic             tb_clear;
    logic             tick;
    logic [CNT_W-1:0] tick_cnt;
    logic [31:0]      tick_cnt_w;

    assign tick_cnt_w = 32'(tick_cnt);

    key_tick_gen #(
        .TICK_CYC (TICK_CYC),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clear_i (tb_clear),
        .tick_o  (tick),
        .count_o (tick_cnt)
    );

    // Next-state and event decode. Each state checks the key level first so a
    // key edge pre-empts any threshold reached on the same cycle.
    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_down) begin
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (!key_down) begin
                    state_d = ST_WAIT2;
                end else if (threshold_met(tick_cnt_w, tick, LONG_TICKS)) begin
                    state_d      = ST_HOLD;
                    ev_d.long_ev = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!key_down) begin
                    state_d = ST_IDLE;
                end else if (threshold_met(tick_cnt_w, tick, REPEAT_TICKS)) begin
                    ev_d.repeat_ev = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (key_down) begin
                    state_d        = ST_PRESS2;
                    ev_d.double_ev = 1'b1;
                end else if (threshold_met(tick_cnt_w, tick, DCLICK_TICKS)) begin
                    state_d       = ST_IDLE;
                    ev_d.short_ev = 1'b1;
                end
            end
            ST_PRESS2: begin
                // Second press of a double click: no long/repeat detection.
                if (!key_down) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The timebase restarts whenever a state is entered and after every
        // repeat, so each threshold is measured from that edge. It is also
        // held clear while idle so a new press always starts from zero.
        tb_clear = (state_d != state_q) || ev_d.repeat_ev || (state_q == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
        end
    end

    assign ev_short  = ev_q.short_ev;
    assign ev_double = ev_q.double_ev;
    assign ev_long   = ev_q.long_ev;
    assign ev_repeat = ev_q.repeat_ev;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumer of the debounced key level produced by the key debouncer; classifies presses into short, double, long and auto-repeat events.
- Sits between the debouncer and the application control logic (menu/mode FSMs).
- Outputs single-cycle event strobes synchronous to clk_i.

Parameters:
- TICK_CYC, 100_000, clk_i cycles per time tick (1 ms at 100 MHz); must be at least 1.
- LONG_TICKS, 1000, hold time in ticks before ev_long; must be at least 1.
- REPEAT_TICKS, 200, interval in ticks between ev_repeat strobes while held after ev_long; must be at least 1.
- DCLICK_TICKS, 300, window in ticks after first release in which a second press counts as a double click; must be at least 1.
- CNT_W, 16, tick counter width; must hold max(LONG_TICKS, REPEAT_TICKS, DCLICK_TICKS).

Ports:
- clk_i  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_down  input  1  debounced key level, 1 = pressed, synchronous to clk_i
- ev_short  output  1  one-cycle strobe: single short press completed
- ev_double  output  1  one-cycle strobe: second press inside the double-click window
- ev_long  output  1  one-cycle strobe: hold reached LONG_TICKS
- ev_repeat  output  1  one-cycle strobe: auto-repeat while held after ev_long
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prescaler=0, tick counter=0, all ev_* outputs=0, busy=0.
- Reset mid-operation aborts any pending event; no strobe is emitted during or on release of reset.
- Timebase:
  - The prescaler counts 0..TICK_CYC-1 and generates a tick when it equals TICK_CYC-1.
  - The tick counter increments on each tick.
  - Both the prescaler and the tick counter clear on every state change and on every ev_repeat.
  - A threshold of N ticks is met on the clock where the tick counter equals N-1 and a tick occurs. That is exactly N*TICK_CYC clocks after the edge that entered the state.
- All ev_* outputs are registered. Each strobe is high for the one cycle following the edge on which its transition is taken. Strobes are mutually exclusive.
- State machine (key_down is sampled at each rising edge):
  - IDLE:
    - key_down=1 -> PRESS1.
  - PRESS1:
    - key_down=0 -> WAIT2.
    - Otherwise, LONG_TICKS met -> HOLD, with ev_long.
  - HOLD:
    - key_down=0 -> IDLE; no ev_short.
    - Otherwise, REPEAT_TICKS met -> stay in HOLD, with ev_repeat; timebase restarts.
  - WAIT2:
    - key_down=1 -> PRESS2, with ev_double.
    - Otherwise, DCLICK_TICKS met -> IDLE, with ev_short.
  - PRESS2:
    - key_down=0 -> IDLE.
    - No long or repeat detection in this state.
- Priority on simultaneous events: a key_down change always beats a threshold in the same cycle.
  - Release on the LONG threshold cycle gives WAIT2, no ev_long.
  - Press on the DCLICK timeout cycle gives ev_double, no ev_short.
  - Release on a repeat cycle gives no ev_repeat.
- Counters saturate: they never wrap while in a state, because every threshold forces a state change or a timebase restart.
- busy=1 in PRESS1, HOLD, WAIT2 and PRESS2.
- Event latency from the qualifying key edge or threshold: 1 cycle.

Decomposition:
- Shared package key_pkg holds:
  - the state encoding constants (IDLE=3'd0, PRESS1=3'd1, HOLD=3'd2, WAIT2=3'd3, PRESS2=3'd4);
  - default timing constants, shared with the debouncer's CLK_freq.
- One sub-module: key_tick_gen. It contains the prescaler plus the tick counter, with clear input, tick output and count output, parameterised by TICK_CYC and CNT_W.
- The FSM and output registers stay in the top module.

Test Plan:
Use TICK_CYC=10, LONG_TICKS=20, REPEAT_TICKS=5, DCLICK_TICKS=8 for all scenarios.
1. Press for 50 clocks, release, stay idle for 200 clocks -> a single ev_short exactly 80 clocks after the release edge; no other strobes; busy returns to 0.
2. Press 50 clocks, release 30 clocks, press 40 clocks, release -> ev_double one cycle after the second press edge; no ev_short and no ev_long; IDLE after the final release.
3. Hold for 320 clocks -> ev_long at clock 200 after the press, then ev_repeat at 250 and 300; release gives IDLE with no ev_short.
4. Release on exactly the 200th clock after the press -> no ev_long; WAIT2 entered; ev_short 80 clocks later.
5. Second press on exactly the 80th clock after the first release -> ev_double, not ev_short.
6. Assert rst_n=0 during HOLD and during WAIT2 -> all outputs 0 immediately (asynchronously); no strobe after reset release with key_down=0.
